// File: rtl/corescore_uart_rx_stream.sv
// rtl/corescore_uart_rx_stream.sv - 8N1 UART receiver feeding a valid/ready byte stream
// Two-flop synchroniser, mid-bit sampling FSM, framing/overrun pulses and a small output FIFO.
module corescore_uart_rx_stream #(
  parameter int clk_freq_hz = 50_000_000,
  parameter int baud_rate   = 57600,
  parameter int depth       = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_frame_err,
  output logic       o_overrun
);

  localparam int CPB = clk_freq_hz / baud_rate;
  localparam int CW  = $clog2(CPB);
  localparam int AW  = $clog2(depth);
  localparam logic [CW-1:0] C_FULL  = CW'(CPB - 1);
  localparam logic [CW-1:0] C_HALF  = CW'(CPB / 2 - 1);
  localparam logic [AW:0]   C_DEPTH = (AW + 1)'(depth);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t          r_state;
  logic            r_sync1;
  logic            r_sync2;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bit;
  logic [7:0]      r_sh;
  logic            r_frame_err;
  logic            r_overrun;

  logic [7:0]      r_mem [depth];
  logic [AW-1:0]   r_wr;
  logic [AW-1:0]   r_rd;
  logic [AW:0]     r_count;

  logic            w_stop_sample;
  logic            w_push;
  logic            w_pop;
  logic            w_full;
  logic            w_accept;

  assign w_stop_sample = (r_state == S_STOP) && (r_cnt == '0);
  assign w_push        = w_stop_sample && r_sync2;
  assign o_valid       = (r_count != '0);
  assign w_pop         = o_valid && i_ready;
  assign w_full        = (r_count == C_DEPTH);
  // A full FIFO still takes the byte when the consumer frees a slot on the same edge.
  assign w_accept      = w_push && (!w_full || w_pop);

  assign o_data      = r_mem[r_rd];
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_sh        <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= i_uart_rx;
      r_sync2     <= r_sync1;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_sync2) begin
            r_state <= S_START;
            r_cnt   <= C_HALF;
          end
        end
        S_START: begin
          if (r_cnt == '0) begin
            if (r_sync2) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DATA;
              r_cnt   <= C_FULL;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (r_cnt == '0) begin
            r_sh[r_bit] <= r_sync2;
            r_cnt       <= C_FULL;
            if (r_bit == 3'd7) begin
              r_state <= S_STOP;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_STOP: begin
          if (r_cnt == '0) begin
            if (r_sync2) begin
              r_state <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        // A held-low line (break) must return high before another start bit is looked for.
        S_WAIT_HIGH: begin
          if (r_sync2) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < depth; i++) begin
        r_mem[i] <= '0;
      end
      r_wr      <= '0;
      r_rd      <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_accept) begin
        r_mem[r_wr] <= r_sh;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_corescore_uart_rx_stream.sv
// tb/tb_corescore_uart_rx_stream.sv - directed bench for the UART receive stream block
// CPB=10 line timing; popped bytes and error pulses are collected on the falling edge.
module tb_corescore_uart_rx_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;

  always #5 clk = ~clk;

  corescore_uart_rx_stream #(
    .clk_freq_hz(1_000_000),
    .baud_rate  (100_000),
    .depth      (4)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_uart_rx  (rx),
    .o_data     (data),
    .o_valid    (valid),
    .i_ready    (ready),
    .o_frame_err(ferr),
    .o_overrun  (ovr)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] rx_q[$];
  int         pop_cyc[$];
  int         n_ferr = 0;
  int         n_ovr = 0;
  int         n_both = 0;
  int         last_ovr_cyc = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) begin
        rx_q.push_back(data);
        pop_cyc.push_back(cyc);
      end
      if (ferr) n_ferr = n_ferr + 1;
      if (ovr) begin
        n_ovr = n_ovr + 1;
        last_ovr_cyc = cyc;
      end
      if (ferr && ovr) n_both = n_both + 1;
    end
  end

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered #1 after an edge; the start bit is driven at once so frames can run back-to-back.
  task automatic send_byte(input logic [7:0] b, input logic stop, input bit pulse_ready,
                           output int start_c);
    rx = 1'b0;
    start_c = cyc + 1;
    for (int k = 0; k < 8; k++) begin
      repeat (10) @(posedge clk);
      #1 rx = b[k];
    end
    repeat (10) @(posedge clk);
    #1 rx = stop;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (pulse_ready && i == 6) ready = 1'b1;
      if (pulse_ready && i == 7) ready = 1'b0;
    end
  endtask

  task automatic expect_byte(input string tag, input int idx, input logic [7:0] exp);
    if (idx < rx_q.size()) check(tag, {24'd0, rx_q[idx]}, {24'd0, exp});
  endtask

  int s0, s1, s2, base, ferr0, ovr0;
  logic [7:0] fill [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    ready = 1'b1;
    idle(3);
    check("reset_valid", {31'd0, valid}, 32'd0);
    check("reset_data", {24'd0, data}, 32'd0);
    check("reset_ferr", {31'd0, ferr}, 32'd0);
    check("reset_ovr", {31'd0, ovr}, 32'd0);
    rst = 1'b0;
    idle(5);

    // 1: back-to-back frames and start-edge-to-valid latency
    send_byte(8'h55, 1'b1, 1'b0, s1);
    send_byte(8'hA3, 1'b1, 1'b0, s2);
    idle(5);
    check("t1_count", rx_q.size(), 2);
    expect_byte("t1_byte0", 0, 8'h55);
    expect_byte("t1_byte1", 1, 8'hA3);
    if (pop_cyc.size() >= 2) begin
      check("t1_latency0", pop_cyc[0] - s1, 97);
      check("t1_latency1", pop_cyc[1] - s2, 97);
    end
    check("t1_errs", n_ferr + n_ovr, 0);

    // 2: short low glitch is rejected by the start-bit check
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(20);
    check("t2_valid", {31'd0, valid}, 32'd0);
    check("t2_count", rx_q.size(), 2);
    check("t2_ferr", n_ferr, 0);

    // 3: framing error with line held low, then a clean frame
    send_byte(8'h3C, 1'b0, 1'b0, s0);
    idle(10);
    rx = 1'b1;
    idle(15);
    check("t3_ferr", n_ferr, 1);
    check("t3_no_byte", rx_q.size(), 2);
    send_byte(8'h81, 1'b1, 1'b0, s0);
    idle(5);
    check("t3_count", rx_q.size(), 3);
    expect_byte("t3_byte", 2, 8'h81);

    // 4: overrun on the fifth byte while the consumer stalls
    ready = 1'b0;
    ovr0 = n_ovr;
    for (int i = 0; i < 5; i++) send_byte(8'(i + 1), 1'b1, 1'b0, s0);
    idle(3);
    check("t4_ovr", n_ovr - ovr0, 1);
    check("t4_ovr_time", last_ovr_cyc - s0, 97);
    check("t4_head_hold", {24'd0, data}, 32'h01);
    check("t4_valid_full", {31'd0, valid}, 32'd1);
    base = rx_q.size();
    ready = 1'b1;
    idle(8);
    check("t4_count", rx_q.size() - base, 4);
    for (int i = 0; i < 4; i++) expect_byte("t4_order", base + i, fill[i]);
    check("t4_drained", {31'd0, valid}, 32'd0);

    // 5: push into a full FIFO on the same edge as a pop
    ready = 1'b0;
    ovr0 = n_ovr;
    for (int i = 0; i < 4; i++) send_byte(fill[i], 1'b1, 1'b0, s0);
    base = rx_q.size();
    send_byte(8'h06, 1'b1, 1'b1, s0);
    idle(3);
    check("t5_no_ovr", n_ovr - ovr0, 0);
    check("t5_pulse_pop", rx_q.size() - base, 1);
    expect_byte("t5_popped", base, 8'h01);
    ready = 1'b1;
    idle(8);
    check("t5_count", rx_q.size() - base, 5);
    expect_byte("t5_b0", base + 1, 8'h02);
    expect_byte("t5_b1", base + 2, 8'h03);
    expect_byte("t5_b2", base + 3, 8'h04);
    expect_byte("t5_b3", base + 4, 8'h06);
    check("t5_drained", {31'd0, valid}, 32'd0);

    // 6: reset in the middle of a frame abandons it
    ferr0 = n_ferr;
    ovr0 = n_ovr;
    base = rx_q.size();
    rx = 1'b0;
    idle(10);
    for (int k = 0; k < 4; k++) begin
      rx = k[0] ? 1'b1 : 1'b0;
      idle(10);
    end
    rx = 1'b1;
    idle(5);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    check("t6_valid_after_rst", {31'd0, valid}, 32'd0);
    idle(20);
    send_byte(8'h0F, 1'b1, 1'b0, s0);
    idle(5);
    check("t6_count", rx_q.size() - base, 1);
    expect_byte("t6_byte", base, 8'h0F);
    check("t6_no_errs", (n_ferr - ferr0) + (n_ovr - ovr0), 0);
    check("never_both", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
